cplx_seq_core: RTL

//  Parametrised complex-arithmetic sequencer. It fetches instructions from a shared

---
 rtl/cplx_seq_core.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cplx_seq_core.sv
// cplx_seq_core: complex ADD/SUB/MUL sequencer over a shared single-port synchronous memory.
// Latency: ADD/SUB 7 cycles, MUL 10 cycles, HALT 3 cycles (FETCH, DECODE, DONE).
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
//
// Build option: define CPX_SAT_EN to clamp out-of-range result components.
// Without it, the low DW bits are kept (wrap-around). ovf behaves the same in both builds.
//
// Parameters: DW component width (word = {re, im}, 2*DW bits); AW address width.
// The instruction fields must fit in a word: 2 + 3*AW <= 2*DW.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, start_pc   run request and first instruction address (IDLE only)
//   busy, done        busy from the cycle after start until DONE ends; done pulses in DONE
//   ovf               sticky overflow of any result component, cleared by start
//   pc_o              current program counter
//   mem_addr/we/wdata registered memory request; mem_we is high only in WB
//   mem_rdata         read data, valid the cycle after the address is presented
//
// Instruction word: op[2DW-1:2DW-2] (00 ADD, 01 SUB, 10 MUL, 11 HALT),
//   src1[3AW-1:2AW], src2[2AW-1:AW], dst[AW-1:0]; remaining bits ignored.
module cplx_seq_core #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   start_pc,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [AW-1:0]   pc_o,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [2*DW-1:0] mem_wdata,
  input  logic [2*DW-1:0] mem_rdata
);

  localparam int WW   = 2 * DW;
  localparam int ACCW = 2 * DW + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // Signed DW range limits, expressed at accumulator width.
  localparam logic signed [ACCW-1:0] RMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] RMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RDA,
    S_RDB,
    S_LATB,
    S_EX,
    S_WB,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [AW-1:0]          pc;
  logic [AW-1:0]          mem_addr_nxt;
  logic [WW-1:0]          ir;
  logic [WW-1:0]          opa;
  logic [WW-1:0]          opb;
  logic signed [ACCW-1:0] acc_re;
  logic signed [ACCW-1:0] acc_im;
  logic [1:0]             ex_cnt;

  logic [1:0]             ir_op;
  logic signed [DW-1:0]   opa_re, opa_im, opb_re, opb_im;
  logic signed [DW-1:0]   mul_x, mul_y;
  logic signed [WW-1:0]   mul_x_ext, mul_y_ext, prod;
  logic signed [ACCW-1:0] prod_ext;
  logic [DW:0]            as_re, as_im;
  logic signed [ACCW-1:0] res_re, res_im;
  logic                   res_ovf;
  logic [WW-1:0]          res_word;
  logic                   unused_ir;

  assign ir_op  = ir[WW-1 -: 2];
  assign opa_re = opa[WW-1:DW];
  assign opa_im = opa[DW-1:0];
  assign opb_re = opb[WW-1:DW];
  assign opb_im = opb[DW-1:0];

  // Only op/src2/dst are consumed from IR; src1 is taken straight off the read bus.
  assign unused_ir = ^ir;

  // ------------------------------------------------------------------
  // Shared multiplier. With A = a+bi and B = c+di the four EX cycles
  // form a*c, b*d, a*d, b*c in that order.
  // ------------------------------------------------------------------
  always_comb begin
    mul_x = opa_re;
    mul_y = opb_re;
    case (ex_cnt)
      2'd0: begin mul_x = opa_re; mul_y = opb_re; end
      2'd1: begin mul_x = opa_im; mul_y = opb_im; end
      2'd2: begin mul_x = opa_re; mul_y = opb_im; end
      default: begin mul_x = opa_im; mul_y = opb_re; end
    endcase
  end

  assign mul_x_ext = {{DW{mul_x[DW-1]}}, mul_x};
  assign mul_y_ext = {{DW{mul_y[DW-1]}}, mul_y};
  assign prod      = mul_x_ext * mul_y_ext;
  assign prod_ext  = {prod[WW-1], prod};

  // ADD/SUB at DW+1 bits, which can never overflow itself.
  always_comb begin
    if (ir_op == OP_SUB) begin
      as_re = {opa_re[DW-1], opa_re} - {opb_re[DW-1], opb_re};
      as_im = {opa_im[DW-1], opa_im} - {opb_im[DW-1], opb_im};
    end else begin
      as_re = {opa_re[DW-1], opa_re} + {opb_re[DW-1], opb_re};
      as_im = {opa_im[DW-1], opa_im} + {opb_im[DW-1], opb_im};
    end
  end

  // Unreduced result seen on the last EX cycle. For MUL the real part is
  // already final; the imaginary part still needs the b*c term of EX3.
  always_comb begin
    res_re = acc_re;
    res_im = acc_im + prod_ext;
    if (ir_op != OP_MUL) begin
      res_re = {{(ACCW-DW-1){as_re[DW]}}, as_re};
      res_im = {{(ACCW-DW-1){as_im[DW]}}, as_im};
    end
  end

  function automatic logic out_of_range(input logic signed [ACCW-1:0] v);
    return (v > RMAX) || (v < RMIN);
  endfunction

  function automatic logic [DW-1:0] reduce(input logic signed [ACCW-1:0] v);
`ifdef CPX_SAT_EN
    if (v > RMAX) begin
      return RMAX[DW-1:0];
    end else if (v < RMIN) begin
      return RMIN[DW-1:0];
    end
`endif
    return v[DW-1:0];
  endfunction

  assign res_ovf  = out_of_range(res_re) || out_of_range(res_im);
  assign res_word = {reduce(res_re), reduce(res_im)};

  // ------------------------------------------------------------------
  // Next state and next memory address. mem_addr is a register, so the
  // address for a state is loaded on the edge that enters that state;
  // the read data then arrives one state later.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    mem_addr_nxt = mem_addr;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_FETCH;
          mem_addr_nxt = start_pc;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (mem_rdata[WW-1 -: 2] == OP_HALT) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt    = S_RDA;
          mem_addr_nxt = mem_rdata[3*AW-1 -: AW];
        end
      end
      S_RDA: begin
        state_nxt    = S_RDB;
        mem_addr_nxt = ir[2*AW-1 -: AW];
      end
      S_RDB:  state_nxt = S_LATB;
      S_LATB: state_nxt = S_EX;
      S_EX: begin
        if ((ir_op != OP_MUL) || (ex_cnt == 2'd3)) begin
          state_nxt    = S_WB;
          mem_addr_nxt = ir[AW-1:0];
        end
      end
      S_WB: begin
        state_nxt    = S_FETCH;
        mem_addr_nxt = pc + 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // State and datapath registers.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      opa       <= '0;
      opb       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      ex_cnt    <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      mem_addr <= mem_addr_nxt;
      // WB lasts exactly one cycle, so this yields a single write strobe.
      mem_we   <= (state_nxt == S_WB);

      case (state)
        S_IDLE: begin
          if (start) begin
            pc   <= start_pc;
            ovf  <= 1'b0;
            busy <= 1'b1;
          end
        end
        S_DECODE: ir  <= mem_rdata;
        S_RDB:    opa <= mem_rdata;
        S_LATB: begin
          opb    <= mem_rdata;
          ex_cnt <= 2'd0;
        end
        S_EX: begin
          ex_cnt <= ex_cnt + 2'd1;
          if (ir_op == OP_MUL) begin
            case (ex_cnt)
              2'd0:    acc_re <= prod_ext;
              2'd1:    acc_re <= acc_re - prod_ext;
              2'd2:    acc_im <= prod_ext;
              default: acc_im <= acc_im + prod_ext;
            endcase
          end
          if (state_nxt == S_WB) begin
            mem_wdata <= res_word;
            if (res_ovf) begin
              ovf <= 1'b1;
            end
          end
        end
        S_WB:   pc   <= pc + 1'b1;
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign pc_o = pc;

endmodule
